// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch-stage types.
// Opcodes live in instr[INSTR_W-1 -: 4].
package isa_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;

  localparam logic [3:0] OP_RARITH = 4'b0000;
  localparam logic [3:0] OP_IARITH = 4'b1000;
  localparam logic [3:0] OP_LOAD   = 4'b1001;
  localparam logic [3:0] OP_STORE  = 4'b0101;
  localparam logic [3:0] OP_RCMP   = 4'b0010;
  localparam logic [3:0] OP_ICMP   = 4'b1010;
  localparam logic [3:0] OP_BRANCH = 4'b0110;
  localparam logic [3:0] OP_JAL    = 4'b1011;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC select: sequential increment and redirect target.
// Jump wins over a taken branch; branch is relative to last_pc.
module fetch_next_pc
  import isa_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OFF_W  = 8
) (
  input  logic [ADDR_W-1:0] seq_base,
  input  logic [ADDR_W-1:0] last_pc,
  input  logic              jump,
  input  logic              branch,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [OFF_W-1:0]  branch_offset,
  output logic              redirect,
  output logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] seq_pc
);

  logic [ADDR_W-1:0] off_ext;

  assign off_ext = {{(ADDR_W-OFF_W){branch_offset[OFF_W-1]}},
                    branch_offset};

  assign seq_pc   = seq_base + ADDR_W'(1);
  assign redirect = jump | (branch & branch_taken);

  always_comb begin
    target = seq_pc;
    priority case (1'b1)
      jump:                    target = jump_target;
      (branch & branch_taken): target = last_pc + off_ext;
      default:                 target = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request, one-entry buffer.
// Optional FETCH_HALT_EN: consuming opcode 4'b1111 parks fetch in HALT.
module fetch_unit
  import isa_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter int              OFF_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [3:0]         opcode,
  input  logic               id_ready,
  input  logic               jump,
  input  logic               branch,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic [OFF_W-1:0]   branch_offset,
  output logic               halted
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  last_pc_q, last_pc_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               drop_q, drop_d;
  logic               started_q;

  logic               redirect;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  seq_pc;

  fetch_next_pc #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_next_pc (
    .seq_base      (instr_pc_q),
    .last_pc       (last_pc_q),
    .jump          (jump),
    .branch        (branch),
    .branch_taken  (branch_taken),
    .jump_target   (jump_target),
    .branch_offset (branch_offset),
    .redirect      (redirect),
    .target        (target),
    .seq_pc        (seq_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    last_pc_d  = last_pc_q;
    instr_pc_d = instr_pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    drop_d     = drop_q;
    unique case (state_q)
      ST_REQ: begin
        if (redirect) pc_d = target;
        if (started_q && imem_ready) begin
          state_d = ST_WAIT;
          // request already left with the old pc
          if (redirect) drop_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
          if (drop_q || redirect) begin
            drop_d = 1'b0;
            if (redirect) pc_d = target;
          end else begin
            valid_d    = 1'b1;
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = ST_HOLD;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
          pc_d   = target;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = ST_REQ;
        end else if (id_ready) begin
          valid_d   = 1'b0;
          pc_d      = seq_pc;
          last_pc_d = instr_pc_q;
          state_d   = ST_REQ;
`ifdef FETCH_HALT_EN
          if (instr_q[INSTR_W-1 -: 4] == OP_HALT)
            state_d = ST_HALT;
`endif
        end
      end
`ifdef FETCH_HALT_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      last_pc_q  <= RESET_PC;
      instr_pc_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      last_pc_q  <= last_pc_d;
      instr_pc_q <= instr_pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
      started_q  <= 1'b1;
    end
  end

  assign imem_req    = started_q & (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign opcode      = instr_q[INSTR_W-1 -: 4];
`ifdef FETCH_HALT_EN
  assign halted      = (state_q == ST_HALT);
`else
  assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model.
// Model tracks outstanding request, stale flag and one-entry buffer.
module tb_fetch_unit;

  localparam logic [15:0] RPC = 16'h0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [3:0]  opcode;
  logic        id_ready = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] jump_target = '0;
  logic [7:0]  branch_offset = '0;
  logic        halted;

  fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .OFF_W    (8),
    .RESET_PC (RPC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .opcode        (opcode),
    .id_ready      (id_ready),
    .jump          (jump),
    .branch        (branch),
    .branch_taken  (branch_taken),
    .jump_target   (jump_target),
    .branch_offset (branch_offset),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model
  logic [15:0] m_pc, m_last, m_buf, m_buf_pc;
  bit m_out, m_stale, m_buf_v, m_started, m_halted, m_in_rst;

  // memory environment
  int          resp_cnt = 0;
  int          lat_lo = 1, lat_hi = 1;
  bit          force_en = 0;
  logic [15:0] force_data = '0;
  logic [15:0] acc_q[$];
  int          valid_seen = 0;

  function automatic bit m_req();
    return m_started && !m_out && !m_buf_v && !m_halted;
  endfunction

  task automatic step(input bit r, input bit rdy, input bit idr,
                      input bit j, input bit b, input bit bt,
                      input logic [15:0] jt, input logic [7:0] off,
                      input bit spur);
    bit rv, redir, cur_req;
    logic [15:0] d, tgt;
    rv = 0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) rv = 1;
    end
    if (spur && resp_cnt == 0 && !m_out) rv = 1;
    d = force_en ? force_data : 16'($urandom);
    rst = r; imem_ready = rdy; id_ready = idr;
    jump = j; branch = b; branch_taken = bt;
    jump_target = jt; branch_offset = off;
    imem_rvalid = rv; imem_rdata = d;
    if (!r && imem_req && rdy) begin
      resp_cnt = int'($urandom_range(lat_hi, lat_lo));
      acc_q.push_back(imem_addr);
    end
    m_in_rst = r;
    if (r) begin
      m_pc = RPC; m_last = RPC; m_buf = '0; m_buf_pc = '0;
      m_out = 0; m_stale = 0; m_buf_v = 0;
      m_started = 0; m_halted = 0;
    end else begin
      cur_req = m_req();
      redir = (j || (b && bt)) && !m_halted;
      tgt = j ? jt : 16'(m_last + {{8{off[7]}}, off});
      if (m_halted) begin
      end else if (m_buf_v) begin
        if (redir) begin
          m_buf_v = 0; m_pc = tgt;
        end else if (idr) begin
          m_buf_v = 0; m_last = m_buf_pc; m_pc = m_buf_pc + 16'd1;
`ifdef FETCH_HALT_EN
          if (m_buf[15:12] == 4'hF) m_halted = 1;
`endif
        end
      end else if (m_out) begin
        if (rv) begin
          m_out = 0;
          if (m_stale || redir) begin
            m_stale = 0;
            if (redir) m_pc = tgt;
          end else begin
            m_buf_v = 1; m_buf = d; m_buf_pc = m_pc;
          end
        end else if (redir) begin
          m_stale = 1; m_pc = tgt;
        end
      end else begin
        if (cur_req && rdy) begin
          m_out = 1; m_stale = redir;
        end
        if (redir) m_pc = tgt;
      end
      m_started = 1;
    end
    @(posedge clk);
    #1;
    chk("imem_req", imem_req, m_req());
    if (m_req()) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, m_buf_v);
    if (m_buf_v || m_in_rst) begin
      chk("instr", instr, m_buf);
      chk("instr_pc", instr_pc, m_buf_pc);
      chk("opcode", opcode, m_buf[15:12]);
    end
    chk("halted", halted, m_halted);
    if (instr_valid) valid_seen++;
  endtask

  task automatic idle(input int n, input bit rdy, input bit idr);
    for (int i = 0; i < n; i++) step(0, rdy, idr, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic to_hold();
    for (int i = 0; i < 30 && !m_buf_v; i++) idle(1, 1, 0);
    chk("reach_hold", instr_valid, 1);
  endtask

  task automatic to_req();
    for (int i = 0; i < 30 && !m_req(); i++) idle(1, 0, 1);
    chk("reach_req", imem_req, 1);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, '0, '0, 0);
    step(1, 0, 0, 0, 0, 0, '0, '0, 0);

    // sequential fetch, 1 instruction per 3 cycles
    acc_q.delete(); valid_seen = 0;
    idle(9, 1, 1);
    chk("seq_addr0", acc_q[0], 16'h0010);
    chk("seq_addr1", acc_q[1], 16'h0011);
    chk("seq_addr2", acc_q[2], 16'h0012);
    chk("seq_valid_cnt", valid_seen, 3);

    // wrap from 0xFFFF
    to_hold();
    step(0, 0, 0, 1, 0, 0, 16'hFFFF, '0, 0);
    acc_q.delete();
    to_hold();
    idle(2, 1, 1);
    chk("wrap_ffff", acc_q[0], 16'hFFFF);
    chk("wrap_0000", acc_q[1], 16'h0000);

    // taken and not-taken branch from last_pc 0x0020
    for (int t = 0; t < 2; t++) begin
      to_hold();
      step(0, 0, 0, 1, 0, 0, 16'h0020, '0, 0);
      to_hold();
      step(0, 0, 1, 0, 0, 0, '0, '0, 0);
      step(0, 0, 0, 0, 1, (t == 0), '0, 8'hFC, 0);
      acc_q.delete();
      idle(1, 1, 0);
      chk(t == 0 ? "br_taken" : "br_not_taken", acc_q[0],
          t == 0 ? 16'h001C : 16'h0021);
    end

    // jump while waiting: response dropped
    to_hold();
    idle(1, 0, 1);
    lat_lo = 3; lat_hi = 3;
    idle(1, 1, 0);
    step(0, 0, 0, 1, 0, 0, 16'h0100, '0, 0);
    acc_q.delete(); valid_seen = 0;
    idle(3, 1, 1);
    chk("drop_no_valid", valid_seen, 0);
    chk("drop_target", acc_q[0], 16'h0100);
    lat_lo = 1; lat_hi = 1;

    // stall in HOLD, redirect on cycle 3
    to_hold();
    idle(2, 1, 0);
    step(0, 1, 1, 1, 0, 0, 16'h0200, '0, 0);
    chk("flush_valid", instr_valid, 0);
    acc_q.delete();
    idle(2, 1, 0);
    chk("flush_target", acc_q[0], 16'h0200);

`ifdef FETCH_HALT_EN
    to_req();
    force_en = 1; force_data = 16'hF000;
    to_hold();
    force_en = 0;
    step(0, 1, 1, 0, 0, 0, '0, '0, 0);
    acc_q.delete();
    for (int i = 0; i < 10; i++)
      step(0, 1, 1, 1, 0, 0, 16'h0300, '0, 0);
    chk("halt_flag", halted, 1);
    chk("halt_no_req", acc_q.size(), 0);
    step(1, 0, 0, 0, 0, 0, '0, '0, 0);
    acc_q.delete();
    idle(3, 1, 1);
    chk("halt_resume", acc_q[0], RPC);
`else
    to_req();
`endif

    // randomized traffic
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199, 0) == 0),
           ($urandom_range(9, 0) < 7),
           ($urandom_range(9, 0) < 6),
           ($urandom_range(19, 0) == 0),
           ($urandom_range(11, 0) == 0),
           1'($urandom),
           16'($urandom), 8'($urandom),
           ($urandom_range(19, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of `control_unit`. It owns the program counter, issues single-outstanding requests to instruction memory, and buffers one fetched instruction. It presents the instruction and its 4-bit opcode to decode and control. It consumes the `jump`/`branch` decisions fed back from control/ALU to redirect the PC and flush stale fetches.

## Interface
- `ADDR_W`, 16: PC and instruction-memory word-address width.
- `INSTR_W`, 16: instruction width; opcode is `instr[INSTR_W-1 -: 4]`.
- `OFF_W`, 8: branch offset width, two's complement.
- `RESET_PC`, 0: PC value loaded on reset.
- `clk`  in  1  the single clock; everything is rising-edge.
- `rst`  in  1  synchronous reset, active-high.
- `imem_req`  out  1  request valid to instruction memory.
- `imem_addr`  out  ADDR_W  word address of the request.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  INSTR_W  read data.
- `instr_valid`  out  1  buffered instruction available to decode.
- `instr`  out  INSTR_W  buffered instruction.
- `instr_pc`  out  ADDR_W  address of `instr`.
- `opcode`  out  4  `instr[INSTR_W-1 -: 4]`; feeds `control_unit`.
- `id_ready`  in  1  decode consumes `instr` this cycle.
- `jump`  in  1  redirect to `jump_target`.
- `branch`  in  1  instruction is a branch.
- `branch_taken`  in  1  branch condition true (ALU zero).
- `jump_target`  in  ADDR_W  absolute jump destination.
- `branch_offset`  in  OFF_W  signed word offset relative to the branching instruction.
- `halted`  out  1  fetch stopped (only with `FETCH_HALT_EN`).

## Operation
- FSM states:
  - REQ: drive `imem_req`=1 with `imem_addr`=`pc`. On `imem_ready`, go to WAIT.
  - WAIT: on `imem_rvalid`, capture `imem_rdata`/`pc` into the buffer, set `instr_valid`, and go to HOLD.
  - HOLD: on `id_ready`, clear `instr_valid`, set `pc`←`instr_pc`+1 and `last_pc`←`instr_pc`, and go to REQ.
  - HALT: only exists with `FETCH_HALT_EN`.
- Redirect condition is `redirect = jump | (branch & branch_taken)`. Target selection:
  - Jump: `jump_target`.
  - Taken branch: `last_pc + sext(branch_offset)`, computed modulo 2^ADDR_W.
  - `jump` has priority over `branch`.
- Redirect handling by state (redirect always beats a simultaneous `id_ready`):
  - HOLD: flush the buffer (`instr_valid`←0), set `pc`←target, go to REQ.
  - REQ: replace `imem_addr` with the target the next cycle. If `imem_ready` is in the same cycle, the accepted request is stale: set `drop`.
  - WAIT: set `drop` and latch the target into `pc`.
- The response that arrives while `drop`=1 is discarded (no `instr_valid`). `drop` is then cleared and the FSM goes to REQ at `pc`.
- Sequential PC increment wraps from 2^ADDR_W-1 to 0.
- Only one request is outstanding. `imem_rvalid` outside WAIT is ignored.

## Timing
- Reset values: state REQ with `pc`=`RESET_PC`; `imem_req`=0 during `rst`, asserted from the first cycle after `rst` falls. `instr_valid`=0, `instr`=0, `instr_pc`=0, `opcode`=0, `halted`=0, `drop`=0, `last_pc`=`RESET_PC`.
- `rst` mid-operation abandons any outstanding request; a late `imem_rvalid` after reset is ignored because the FSM is in REQ.
- All outputs are registered or decoded only from registered state; there is no combinational path from any input to any output.
- Best case: request accepted cycle N, `imem_rvalid` cycle N+1, `instr_valid` visible cycle N+2. Throughput is 1 instruction per 3 cycles with `imem_ready`=`id_ready`=1.
- `instr`, `instr_pc` and `opcode` are stable while `instr_valid`=1 and `id_ready`=0.
- Redirect takes effect on the next edge. The new target is presented on `imem_addr` the cycle after redirect when in HOLD/REQ, or after the discarded response when in WAIT.

## Configuration
- `FETCH_HALT_EN` defined:
  - Consuming an instruction with opcode 4'b1111 (`id_ready` in HOLD) moves the FSM to HALT.
  - In HALT: `imem_req`=0, `halted`=1, and redirects are ignored.
  - Only `rst` exits HALT.
- Undefined: opcode 4'b1111 is fetched like any other instruction, the HALT state is absent, and `halted` is tied to 0.

## Structure
- Shared package `isa_pkg`:
  - opcode constants `OP_RARITH`=0000, `OP_IARITH`=1000, `OP_LOAD`=1001, `OP_STORE`=0101, `OP_RCMP`=0010, `OP_ICMP`=1010, `OP_BRANCH`=0110, `OP_JAL`=1011, `OP_HALT`=1111;
  - the fetch state enum typedef;
  - default `ADDR_W`/`INSTR_W`.
- One sub-module `fetch_next_pc`: combinational next-PC/redirect-target select (increment, jump, sign-extended branch add). The FSM and buffer stay in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0x0010, memory always ready with 1-cycle latency, `id_ready`=1 -> `imem_addr` sequence 0x0010, 0x0011, 0x0012; `instr_valid` every 3rd cycle; `instr_pc` matches.
- Wrap: PC at 0xFFFF -> next `imem_addr`=0x0000.
- Branch from `last_pc`=0x0020 with `branch_offset`=0xFC and `branch_taken`=1 -> next fetch 0x001C. Same stimulus with `branch_taken`=0 -> next fetch 0x0021.
- `jump`=1, `jump_target`=0x0100, asserted during WAIT -> the pending response is dropped (no `instr_valid`), then `imem_addr`=0x0100.
- `id_ready` held 0 for 5 cycles in HOLD -> `instr` stable, no new `imem_req`. Redirect in cycle 3 -> buffer flushed, fetch restarts at the target.
- With `FETCH_HALT_EN`, instruction 0xF000 consumed -> `halted`=1 and `imem_req` stays 0 indefinitely. `rst` pulse -> fetch resumes at `RESET_PC`.
